// File: rtl/ws2812b_multi_capture.sv
// ws2812b_multi_capture
//   WS2812B stream sniffer. Decodes the single-wire pulse stream on din,
//   captures the first NUM_PIXELS pixels of every frame into a shadow buffer,
//   commits them to a CPU-visible buffer when the frame ends (line idle), and
//   forwards the rest of the frame on dout so downstream LEDs keep working.
//
// Ports
//   clk       in   1       clock
//   reset     in   1       synchronous, active-high reset
//   din       in   1       WS2812B input, already synchronised to clk
//   dout      out  1       forwarded stream (pixels after NUM_PIXELS), 1-cycle latency
//   address   in   ADDR_W  read address
//   rd_en     in   1       one-cycle read strobe qualifying address
//   data_out  out  8       read data, combinational from address
//   frame_irq out  1       one-cycle pulse when a frame with >=1 pixel is committed
//
// Read map
//   p*BYTES_PER_PIXEL+b : visible pixel p, byte b (wire order G,R,B[,W])
//   2**ADDR_W-1         : status {pix_cnt[5:0], overflow, frame_ready}
//   anything else       : 8'h00
module ws2812b_multi_capture #(
    parameter int CLK_HZ           = 64000000,
    parameter int THRESHOLD_CYCLES = 38,
    parameter int IDLE_US          = 60,
    parameter int NUM_PIXELS       = 4,
    parameter int BYTES_PER_PIXEL  = 3,
    parameter int ADDR_W           = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              din,
    output logic              dout,
    input  logic [ADDR_W-1:0] address,
    input  logic              rd_en,
    output logic [7:0]        data_out,
    output logic              frame_irq
);

    localparam int IDLE_CYC  = CLK_HZ / 1000000 * IDLE_US;
    localparam int NUM_BYTES = NUM_PIXELS * BYTES_PER_PIXEL;
    // One spare bit so the saturated low counter sits above IDLE_CYC-1 and
    // the idle pulse cannot repeat during a long low period.
    localparam int LO_W      = $clog2(IDLE_CYC + 1) + 1;
    localparam int BI_W      = $clog2(NUM_BYTES + 1);
    localparam logic [ADDR_W-1:0] STATUS_ADDR = '1;

    generate
        if (NUM_PIXELS < 1 || NUM_PIXELS > 20 || NUM_BYTES > (2 ** ADDR_W) - 1) begin : g_param_check
            $error("ws2812b_multi_capture: NUM_PIXELS out of range or buffer does not fit below the status address");
        end
    endgenerate

    typedef enum logic [1:0] {
        SYNC,
        CAPTURE,
        FORWARD,
        COMMIT
    } state_t;

    state_t            state;
    state_t            state_next;

    logic              din_q;
    logic              fall_p1;
    logic [7:0]        hi_cnt;
    logic [LO_W-1:0]   lo_cnt;
    logic              bit_valid;
    logic              bit_val;
    logic              idle;

    logic [2:0]        bit_cnt;
    logic [7:0]        shreg;
    logic [BI_W-1:0]   byte_idx;
    logic [7:0]        shadow  [NUM_BYTES];
    logic [7:0]        visible [NUM_BYTES];

    logic [5:0]        pix_cnt;
    logic              overflow;
    logic              frame_ready;
    logic [BI_W-1:0]   commit_pix;
    logic              commit_valid;
    logic              status_rd;

    // Pulse decode: a falling edge of din_q registers into fall_p1, and on that
    // cycle hi_cnt holds the full high time of the bit that just ended.
    assign bit_valid = fall_p1;
    assign bit_val   = (hi_cnt >= 8'(THRESHOLD_CYCLES));
    assign idle      = (lo_cnt == LO_W'(IDLE_CYC - 1));

    // Only whole pixels are committed; a trailing partial pixel is dropped.
    assign commit_pix   = byte_idx / BI_W'(BYTES_PER_PIXEL);
    assign commit_valid = (state == COMMIT) && (commit_pix != '0);
    assign status_rd    = rd_en && (address == STATUS_ADDR);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= SYNC;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        dout       = 1'b0;
        frame_irq  = 1'b0;
        case (state)
            SYNC: begin
                if (idle) state_next = CAPTURE;
            end
            CAPTURE: begin
                if (idle) begin
                    state_next = COMMIT;
                end else if (byte_idx == BI_W'(NUM_BYTES)) begin
                    state_next = FORWARD;
                end
            end
            FORWARD: begin
                dout = din_q;
                if (idle) state_next = COMMIT;
            end
            COMMIT: begin
                frame_irq  = commit_valid;
                state_next = CAPTURE;
            end
            default: state_next = SYNC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            din_q       <= 1'b0;
            fall_p1     <= 1'b0;
            hi_cnt      <= '0;
            lo_cnt      <= '0;
            bit_cnt     <= '0;
            shreg       <= '0;
            byte_idx    <= '0;
            pix_cnt     <= '0;
            overflow    <= 1'b0;
            frame_ready <= 1'b0;
            for (int i = 0; i < NUM_BYTES; i++) begin
                shadow[i]  <= '0;
                visible[i] <= '0;
            end
        end else begin
            // decode stage: input delay, edge detect, high/low timers
            din_q   <= din;
            fall_p1 <= din_q & ~din;

            if (din & ~din_q) begin
                hi_cnt <= '0;
            end else if (din_q && hi_cnt != 8'hFF) begin
                hi_cnt <= hi_cnt + 8'd1;
            end

            if (din_q) begin
                lo_cnt <= '0;
            end else if (lo_cnt != '1) begin
                lo_cnt <= lo_cnt + LO_W'(1);
            end

            // assembly stage: MSB-first shift into bytes, bytes into shadow
            if (state == COMMIT) begin
                bit_cnt  <= '0;
                shreg    <= '0;
                byte_idx <= '0;
            end else if (state == CAPTURE && bit_valid && byte_idx != BI_W'(NUM_BYTES)) begin
                shreg   <= {shreg[6:0], bit_val};
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    for (int i = 0; i < NUM_BYTES; i++) begin
                        if (byte_idx == BI_W'(i)) shadow[i] <= {shreg[6:0], bit_val};
                    end
                    byte_idx <= byte_idx + BI_W'(1);
                end
            end

            // commit stage: status read-clear first so a same-cycle commit wins
            if (status_rd) begin
                frame_ready <= 1'b0;
                overflow    <= 1'b0;
            end
            if (commit_valid) begin
                frame_ready <= 1'b1;
                overflow    <= overflow | frame_ready;
                pix_cnt     <= 6'(commit_pix);
                for (int i = 0; i < NUM_BYTES; i++) begin
                    if (i < int'(commit_pix) * BYTES_PER_PIXEL) visible[i] <= shadow[i];
                end
            end
        end
    end

    always_comb begin
        data_out = 8'h00;
        if (address == STATUS_ADDR) begin
            data_out = {pix_cnt, overflow, frame_ready};
        end else begin
            for (int i = 0; i < NUM_BYTES; i++) begin
                if (address == ADDR_W'(i)) data_out = visible[i];
            end
        end
    end

endmodule
